mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL set the byte-RAM address width (1024 bytes).
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 if_req  input  1  fetch-port read request.
REQ-005 if_addr  input  16  fetch-port byte address of the 16-bit word.
REQ-006 if_rdata  output  16  fetch-port read word.
REQ-007 if_done  output  1  fetch-port completion pulse.
REQ-008 mem_req  input  1  data-port request.
REQ-009 mem_we  input  1  data-port write enable (1 = write, 0 = read).
REQ-010 mem_addr  input  16  data-port byte address.
REQ-011 mem_wdata  input  16  data-port write word.
REQ-012 mem_rdata  output  16  data-port read word.
REQ-013 mem_done  output  1  data-port completion pulse.
REQ-014 ram_addr  output  ADDR_W  shared byte-RAM address.
REQ-015 ram_re / ram_we  output  1 each  byte-RAM read / write strobes.
REQ-016 ram_wdata  output  8  byte-RAM write data.
REQ-017 ram_rdata  input  8  byte-RAM read data; valid one cycle after ram_re.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 FSM states SHALL be IDLE, HI, LO, FIN; transitions: IDLE->HI on accept, HI->LO, LO->FIN, FIN->IDLE unconditionally.
REQ-020 Arbitration SHALL occur only in IDLE; on accept, the winner's port id, addr[ADDR_W-1:0], we and wdata SHALL be latched; inputs SHALL be ignored until the next IDLE.
REQ-021 Word layout SHALL be big-endian: high byte at A, low byte at A+1.
REQ-022 HI: ram_addr=A, ram_re=!we, ram_we=we, ram_wdata=wdata[15:8].
REQ-023 LO: ram_addr=(A+1) mod 2^ADDR_W, ram_re=!we, ram_we=we, ram_wdata=wdata[7:0]; for reads, ram_rdata SHALL be captured as the high byte.
REQ-024 FIN: for reads, ram_rdata SHALL be captured as the low byte; the winner's done SHALL be high for exactly this cycle, with the full word valid on its rdata (combinational merge permitted).
REQ-025 rdata outputs SHALL hold their last completed value until the next read on that port completes; a write SHALL NOT alter rdata.
REQ-026 ram_re, ram_we and both done outputs SHALL be 0 in IDLE; ram_re and ram_we SHALL never be high together.
REQ-027 Requesters SHALL hold req, addr, we and wdata stable until done, and SHALL deassert req on the edge that samples done high; the arbiter does not check this.
REQ-028 Latency SHALL be 3 cycles from the accept edge to done; throughput SHALL be one word per 4 cycles.
REQ-029 Address A=2^ADDR_W-1 SHALL wrap its low byte to address 0; upper address bits beyond ADDR_W SHALL be ignored.

Reset
REQ-030 While rst_n=0: state=IDLE; ram_re=ram_we=0; if_done=mem_done=0; busy=0; if_rdata=mem_rdata=0; ram_addr=0; ram_wdata=0; last-grant=IF. This SHALL take effect immediately, without waiting for clk.
REQ-031 Reset asserted during LO of a write SHALL leave the high byte written and the low byte unwritten; no done SHALL be issued.

Configuration
REQ-032 Macro ARB_RR_EN undefined: fixed priority; mem_req SHALL win over if_req when both are high in IDLE.
REQ-033 Macro ARB_RR_EN defined: round-robin; when both are high, the port not granted last SHALL win; last-grant SHALL update on every accept; after reset, MEM SHALL win the first contention. A single requester SHALL always win in both modes.

Verification
REQ-034 Write: mem_req=1, we=1, addr=0x0010, wdata=0xA55A -> RAM[0x10]=0xA5, RAM[0x11]=0x5A; mem_done high in cycle 3 after accept.
REQ-035 Read back: mem read of 0x0010 -> mem_rdata=0xA55A with mem_done; if_rdata unchanged.
REQ-036 Contention: if_req and mem_req both high in IDLE (macro off) -> mem serviced first, if_done 4 cycles after mem_done; macro on with last-grant=MEM -> IF serviced first.
REQ-037 Wrap: write 0x1234 at addr 0x03FF -> RAM[0x3FF]=0x12, RAM[0x000]=0x34; an IF read at 0x03FF returns 0x1234.
REQ-038 Async reset: rst_n pulled low mid-cycle in LO of a write -> ram_we drops before the next edge, state=IDLE, no done; the high byte persists in RAM.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one byte-wide RAM; each 16-bit access is split into big-endian byte cycles.
// Optional macro ARB_RR_EN selects round-robin arbitration (default: fixed priority, data port wins).
module mem_arbiter #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [15:0]       if_addr,
    output logic [15:0]       if_rdata,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [15:0]       mem_addr,
    input  logic [15:0]       mem_wdata,
    output logic [15:0]       mem_rdata,
    output logic              mem_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_re,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic              busy
);

    // state | meaning
    // IDLE  | arbitrate; accept a request and latch its command
    // HI    | byte access at A (high byte)
    // LO    | byte access at A+1 (low byte); capture high read byte
    // FIN   | capture low read byte, pulse winner's done
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              port_q, port_d;      // 1 = data port, 0 = fetch port
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [7:0]        hi_q, hi_d;
    logic [15:0]       if_rdata_q, if_rdata_d;
    logic [15:0]       mem_rdata_q, mem_rdata_d;
    logic              grant_mem;
    logic [15:0]       word;

    // Address bits above ADDR_W are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr, mem_addr};

`ifdef ARB_RR_EN
    logic last_q, last_d;                   // last grant: 1 = data port, 0 = fetch port

    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && (if_req || mem_req)) begin
            last_d = grant_mem;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        if (if_req && mem_req) begin
            grant_mem = ~last_q;
        end else begin
            grant_mem = mem_req;
        end
    end
`else
    always_comb begin
        grant_mem = mem_req;
    end
`endif

    assign word = {hi_q, ram_rdata};

    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        hi_d        = hi_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        ram_addr    = '0;
        ram_re      = 1'b0;
        ram_we      = 1'b0;
        ram_wdata   = 8'h00;
        if_done     = 1'b0;
        mem_done    = 1'b0;
        if_rdata    = if_rdata_q;
        mem_rdata   = mem_rdata_q;
        busy        = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (if_req || mem_req) begin
                    state_d = HI;
                    port_d  = grant_mem;
                    if (grant_mem) begin
                        addr_d  = mem_addr[ADDR_W-1:0];
                        we_d    = mem_we;
                        wdata_d = mem_wdata;
                    end else begin
                        addr_d  = if_addr[ADDR_W-1:0];
                        we_d    = 1'b0;
                        wdata_d = 16'h0000;
                    end
                end
            end
            HI: begin
                ram_addr  = addr_q;
                ram_re    = ~we_q;
                ram_we    = we_q;
                ram_wdata = wdata_q[15:8];
                state_d   = LO;
            end
            LO: begin
                ram_addr  = addr_q + ADDR_W'(1);
                ram_re    = ~we_q;
                ram_we    = we_q;
                ram_wdata = wdata_q[7:0];
                if (!we_q) begin
                    hi_d = ram_rdata;
                end
                state_d   = FIN;
            end
            FIN: begin
                state_d = IDLE;
                if (port_q) begin
                    mem_done = 1'b1;
                    if (!we_q) begin
                        mem_rdata   = word;
                        mem_rdata_d = word;
                    end
                end else begin
                    if_done = 1'b1;
                    if (!we_q) begin
                        if_rdata   = word;
                        if_rdata_d = word;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            port_q      <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= 16'h0000;
            hi_q        <= 8'h00;
            if_rdata_q  <= 16'h0000;
            mem_rdata_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            hi_q        <= hi_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: byte RAM model, word-level reference model, directed and random traffic.
module tb_mem_arbiter;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              if_req;
    logic [15:0]       if_addr;
    logic [15:0]       if_rdata;
    logic              if_done;
    logic              mem_req;
    logic              mem_we;
    logic [15:0]       mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              mem_done;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_re;
    logic              ram_we;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;
    logic              busy;

    mem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .ram_addr  (ram_addr),
        .ram_re    (ram_re),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Byte RAM seen by the DUT: synchronous write, registered read data.
    logic [7:0] ram_mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= ram_mem[ram_addr];
    end

    // Reference model: word-level view of memory and per-port read results.
    logic [7:0]  exp_mem [0:DEPTH-1];
    logic [15:0] exp_if_rd;
    logic [15:0] exp_mem_rd;
    bit          exp_last;          // 1 = data port granted last
    int          n_cmp;
    int          n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] word_at(input logic [15:0] a);
        int b;
        b = int'(a) % DEPTH;
        return {exp_mem[b], exp_mem[(b + 1) % DEPTH]};
    endfunction

    task automatic chk_idle();
        chk("idle_busy", busy, 0);
        chk("idle_strobes", {ram_re, ram_we, if_done, mem_done}, 0);
    endtask

    task automatic do_txn(input bit is_mem, input bit we, input logic [15:0] addr, input logic [15:0] wdata);
        int a;
        int a1;
        logic [15:0] exp_word;
        a  = int'(addr) % DEPTH;
        a1 = (a + 1) % DEPTH;
        exp_word = word_at(addr);
        @(negedge clk);
        chk_idle();
        if (is_mem) begin
            mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        @(posedge clk);
        exp_last = is_mem;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            chk("txn_busy", busy, 1);
            chk("txn_excl", ram_re & ram_we, 0);
            if (n == 1) begin
                chk("hi_addr", ram_addr, a);
                chk("hi_strobe", {ram_re, ram_we}, {~we, we});
                if (we) chk("hi_wdata", ram_wdata, wdata[15:8]);
            end
            if (n == 2) begin
                chk("lo_addr", ram_addr, a1);
                chk("lo_strobe", {ram_re, ram_we}, {~we, we});
                if (we) chk("lo_wdata", ram_wdata, wdata[7:0]);
            end
            if (n < 3) begin
                chk("early_done", {if_done, mem_done}, 0);
            end
        end
        chk("done_pulse", {if_done, mem_done}, {~is_mem, is_mem});
        chk("fin_strobes", {ram_re, ram_we}, 0);
        if (we) begin
            exp_mem[a]  = wdata[15:8];
            exp_mem[a1] = wdata[7:0];
        end else if (is_mem) begin
            exp_mem_rd = exp_word;
        end else begin
            exp_if_rd = exp_word;
        end
        chk("mem_rdata", mem_rdata, exp_mem_rd);
        chk("if_rdata", if_rdata, exp_if_rd);
        if_req  = 1'b0;
        mem_req = 1'b0;
    endtask

    task automatic contend(input logic [15:0] ai, input logic [15:0] am);
        int t_if;
        int t_mem;
        bit mem_first;
        logic [15:0] w_if;
        logic [15:0] w_mem;
        mem_first = 1'b1;
`ifdef ARB_RR_EN
        mem_first = !exp_last;
`endif
        w_if  = word_at(ai);
        w_mem = word_at(am);
        t_if  = 0;
        t_mem = 0;
        @(negedge clk);
        chk_idle();
        if_req = 1'b1; if_addr = ai;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = am;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (mem_done && t_mem == 0) begin
                t_mem = n;
                chk("cont_mem_rdata", mem_rdata, w_mem);
                mem_req = 1'b0;
            end
            if (if_done && t_if == 0) begin
                t_if = n;
                chk("cont_if_rdata", if_rdata, w_if);
                if_req = 1'b0;
            end
        end
        chk("cont_mem_cycle", t_mem, mem_first ? 3 : 7);
        chk("cont_if_cycle", t_if, mem_first ? 7 : 3);
        if_req = 1'b0;
        mem_req = 1'b0;
        exp_mem_rd = w_mem;
        exp_if_rd  = w_if;
        exp_last   = !mem_first;
    endtask

    initial begin
        logic [7:0] v;
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < DEPTH; i++) begin
            v = 8'($urandom);
            exp_mem[i] = v;
            ram_mem[i] <= v;
        end
        exp_if_rd = 16'h0; exp_mem_rd = 16'h0; exp_last = 1'b0;
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = 16'h0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = 16'h0; mem_wdata = 16'h0;

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {ram_re, ram_we, if_done, mem_done}, 0);
        chk("rst_rdata", {if_rdata, mem_rdata}, 0);
        chk("rst_ram_out", {ram_addr, ram_wdata}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_txn(1'b1, 1'b1, 16'h0010, 16'hA55A);
        chk("wr_hi_byte", ram_mem[16'h010], 8'hA5);
        chk("wr_lo_byte", ram_mem[16'h011], 8'h5A);
        do_txn(1'b1, 1'b0, 16'h0010, 16'h0000);
        chk("rd_back", mem_rdata, 16'hA55A);
        do_txn(1'b1, 1'b0, 16'hFC10, 16'h0000);

        contend(16'h0010, 16'h0200);
        contend(16'h0300, 16'h0011);

        do_txn(1'b1, 1'b1, 16'h03FF, 16'h1234);
        chk("wrap_hi", ram_mem[10'h3FF], 8'h12);
        chk("wrap_lo", ram_mem[10'h000], 8'h34);
        do_txn(1'b0, 1'b0, 16'h03FF, 16'h0000);
        chk("wrap_if_rd", if_rdata, 16'h1234);

        for (int k = 0; k < 30; k++) begin
            bit pm;
            bit w;
            pm = 1'($urandom);
            w  = pm & 1'($urandom);
            do_txn(pm, w, 16'($urandom), 16'($urandom));
        end

        // Reset pulled low in the middle of the low-byte write cycle.
        @(negedge clk);
        chk_idle();
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h0123; mem_wdata = 16'hBEEF;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_we", ram_we, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_we", ram_we, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", {if_done, mem_done}, 0);
        chk("arst_rdata", {if_rdata, mem_rdata}, 0);
        mem_req = 1'b0;
        exp_mem[10'h123] = 8'hBE;
        exp_if_rd = 16'h0; exp_mem_rd = 16'h0; exp_last = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("arst_hi_kept", ram_mem[10'h123], exp_mem[10'h123]);
        chk("arst_lo_untouched", ram_mem[10'h124], exp_mem[10'h124]);
        rst_n = 1'b1;
        do_txn(1'b1, 1'b0, 16'h0123, 16'h0000);
        contend(16'h0040, 16'h0050);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
